// File: rtl/cnn_pkg.sv
// Shared CNN package: pooling-2 state encoding, layer dimensions and pixel type.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WRITE,
        DONE
    } p2_state_t;

    localparam int P2_IN_DIM  = 8;
    localparam int P2_OUT_DIM = 4;
    localparam int PIX_W      = 8;

    typedef logic signed [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/p2_window_addr.sv
// Combinational mapping from window (r,c) and pixel index k to input/output memory addresses.
module p2_window_addr
    import cnn_pkg::*;
#(
    parameter int IN_DIM  = P2_IN_DIM,
    parameter int OUT_DIM = P2_OUT_DIM,
    localparam int IW     = $clog2(IN_DIM),
    localparam int OW     = $clog2(OUT_DIM)
) (
    input  logic [OW-1:0]   r,
    input  logic [OW-1:0]   c,
    input  logic [1:0]      k,
    output logic [2*IW-1:0] in_addr,
    output logic [2*OW-1:0] out_addr
);

    // IN_DIM is a power of two and OUT_DIM = IN_DIM/2, so 2r+k[1] is just {r,k[1]}.
    assign in_addr  = {r, k[1], c, k[0]};
    assign out_addr = {r, c};

endmodule

// File: rtl/p2_pool_ctrl.sv
// Pooling-2 sequencer: 2x2 max-pool over the 8x8 conv-2 map into the 4x4 output map.
// Define P2_POOL_CTRL_RELU_EN to clamp negative window maxima to zero on write.
module p2_pool_ctrl
    import cnn_pkg::*;
#(
    parameter int DATA_W  = PIX_W,
    parameter int IN_DIM  = P2_IN_DIM,
    parameter int OUT_DIM = P2_OUT_DIM,
    localparam int IW     = $clog2(IN_DIM),
    localparam int OW     = $clog2(OUT_DIM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [2*IW-1:0]          in_addr,
    input  logic signed [DATA_W-1:0] in_data,
    output logic [2*OW-1:0]          out_addr,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_we,
    output logic                     busy,
    output logic                     done
);

    localparam logic [OW-1:0] LAST = OW'(OUT_DIM - 1);

    p2_state_t                state_q, state_d;
    logic [OW-1:0]            r_q, r_d, c_q, c_d;
    logic [1:0]               k_q, k_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic [2*OW-1:0]          out_addr_q, out_addr_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_we_q, out_we_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [2*OW-1:0]          win_out_addr;
    logic signed [DATA_W-1:0] final_max;

    p2_window_addr #(
        .IN_DIM  (IN_DIM),
        .OUT_DIM (OUT_DIM)
    ) u_addr (
        .r        (r_q),
        .c        (c_q),
        .k        (k_q),
        .in_addr  (in_addr),
        .out_addr (win_out_addr)
    );

    // Pixel 3 arrives in DRAIN; the write strobe is registered off this value.
    assign final_max = (in_data > max_q) ? in_data : max_q;

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        max_d      = max_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FETCH;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            FETCH: begin
                if (k_q == 2'd1) begin
                    max_d = in_data;
                end else if (k_q != 2'd0 && in_data > max_q) begin
                    max_d = in_data;
                end
                if (k_q == 2'd3) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DRAIN: begin
                max_d      = final_max;
                out_we_d   = 1'b1;
                out_addr_d = win_out_addr;
`ifdef P2_POOL_CTRL_RELU_EN
                out_data_d = final_max[DATA_W-1] ? '0 : final_max;
`else
                out_data_d = final_max;
`endif
                state_d    = WRITE;
            end
            WRITE: begin
                if (r_q == LAST && c_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    c_d     = c_q + OW'(1);
                    if (c_q == LAST) begin
                        r_d = r_q + OW'(1);
                    end
                    k_d     = '0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            max_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
            max_q      <= max_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_we_q   <= out_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign out_we   = out_we_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_p2_pool_ctrl.sv
// Scoreboard bench for p2_pool_ctrl with a registered-read model of the conv-2 memory.
module tb_p2_pool_ctrl;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [5:0]        in_addr;
    logic signed [7:0] in_data;
    logic [3:0]        out_addr;
    logic signed [7:0] out_data;
    logic              out_we;
    logic              busy;
    logic              done;

    p2_pool_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_we   (out_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic signed [7:0] mem [64];
    always @(posedge clk) in_data <= mem[in_addr];

    typedef struct {
        int addr;
        int data;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int writes   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && out_we) begin
            writes++;
            $display("write addr=%0d data=%0d", out_addr, out_data);
            check("we_only_while_busy", int'(busy), 1);
            check("sb_avail", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_addr", int'(out_addr), e.addr);
                check("wr_data", int'(out_data), e.data);
            end
        end
    end

    task automatic push_expected();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                exp_t e;
                int m;
                m = -1000;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (int'(mem[(2*r+dr)*8 + 2*c + dc]) > m)
                            m = int'(mem[(2*r+dr)*8 + 2*c + dc]);
`ifdef P2_POOL_CTRL_RELU_EN
                if (m < 0) m = 0;
`endif
                e.addr = r*4 + c;
                e.data = m;
                sb.push_back(e);
            end
        end
    endtask

    // Pulses start, optionally re-pulses it or aborts with reset, and returns the
    // cycle index (start cycle = 0) at which done was first seen high.
    task automatic run_pass(input int restart_at, input int reset_at, output int n);
        writes = 0;
        push_expected();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("done_low_after_start", int'(done), 0);
        n = 1;
        while (!done && n < 400) begin
            start = (n == restart_at);
            if (n == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("rst_out_we", int'(out_we), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_in_addr", int'(in_addr), 0);
                reset = 1'b0;
                sb.delete();
                return;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic check_pass(input string tag, input int n);
        check({tag, "_done_latency"}, n, 97);
        check({tag, "_writes"}, writes, 16);
        check({tag, "_sb_empty"}, int'(sb.size()), 0);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    endtask

    initial begin
        int n;
        load_ramp();
        repeat (2) @(negedge clk);
        check("reset_in_addr", int'(in_addr), 0);
        check("reset_out_addr", int'(out_addr), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_we", int'(out_we), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_hold_done", int'(done), 0);

        run_pass(-1, -1, n);
        check_pass("ramp", n);
        repeat (3) @(negedge clk);
        check("done_sticky", int'(done), 1);

        // Restart from DONE must reproduce the same results.
        run_pass(-1, -1, n);
        check_pass("ramp_again", n);

        load_ramp();
        mem[0] = -8'sd5; mem[1] = -8'sd3; mem[8] = -8'sd9; mem[9] = -8'sd1;
        run_pass(-1, -1, n);
        check_pass("neg_window", n);

        for (int i = 0; i < 64; i++) mem[i] = -8'sd128;
        run_pass(-1, -1, n);
        check_pass("all_min", n);

        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = -8'sd7; mem[1] = -8'sd20; mem[8] = 8'sd3; mem[9] = 8'sd127;
        run_pass(-1, -1, n);
        check_pass("max_at_k3", n);

        load_ramp();
        run_pass(20, -1, n);
        check_pass("restart_ignored", n);

        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
        run_pass(-1, 40, n);
        repeat (2) @(negedge clk);
        check("post_reset_idle_busy", int'(busy), 0);
        run_pass(-1, -1, n);
        check_pass("after_reset", n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p2_pool_ctrl.md
Name: p2_pool_ctrl

Overview:
- Sequencer for the pooling-2 layer: walks the 8x8 conv-2 output memory in 2x2 windows and computes the max of each window.
- Writes the 16 results, one per cycle slot, into the 4x4 pooling-2 output memory at addresses 0..15.
- Owns both memories' address and write-enable lines while busy, and reports completion to the top-level layer sequencer via done.

Parameters:
- DATA_W, 8, signed pixel width of input and output memories.
- IN_DIM, 8, input feature-map side; must be a power of two.
- OUT_DIM, 4, output side; fixed at IN_DIM/2.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to pool a full map; sampled only in IDLE or DONE.
- in_addr  out  6  conv-2 memory read address, equal to row*IN_DIM+col.
- in_data  in  DATA_W  conv-2 memory read data; valid exactly 1 cycle after in_addr is presented.
- out_addr  out  4  pooling-2 memory write address, equal to r*OUT_DIM+c.
- out_data  out  DATA_W  window maximum.
- out_we  out  1  write strobe for the output memory.
- busy  out  1  high in FETCH, DRAIN and WRITE.
- done  out  1  sticky completion flag.

Behaviour:
- Reset: state=IDLE; in_addr=0, out_addr=0, out_data=0, out_we=0, busy=0, done=0; window counters r=c=0, pixel counter k=0, running max cleared.
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE/DONE with start=1: next state FETCH, r=c=k=0, done cleared.
- IDLE/DONE with start=0: state and outputs hold.
- FETCH, 4 cycles, k=0..3: in_addr = {2r+k[1], 2c+k[0]}.
  - Each cycle with k>0, the datum returned for pixel k-1 is compared into max.
  - When k=1, max is loaded with in_data instead of compared.
  - After k=3, next state DRAIN.
- DRAIN, 1 cycle: the datum for pixel 3 is compared into max; next state WRITE.
- WRITE, 1 cycle: out_we=1, out_addr={r,c}, out_data=max.
  - If r=c=3, next state DONE.
  - Otherwise c increments; on c wrap to 0, r increments. k resets to 0; next state FETCH.
- Timing:
  - 6 cycles per window, 96 cycles from the first FETCH cycle to the last WRITE cycle.
  - done asserts on the cycle after the last write.
- Comparison is signed, DATA_W wide. On equal values the earlier value is kept; the result is identical either way.
- out_we is high only in WRITE. out_addr and out_data hold their last values otherwise.
- start while busy is ignored; no restart or queueing.
- start in DONE begins a new pass; done falls on the first FETCH cycle.
- Reset asserted mid-pass aborts immediately to reset values. No partial write is completed.
- in_addr never exceeds 63 and out_addr never exceeds 15; counters never wrap during a pass.

Optional Feature:
- Macro P2_POOL_CTRL_RELU_EN.
- When defined: in WRITE, out_data = 0 if max is negative, else max. This fuses ReLU into the pooling write.
- When undefined: out_data = raw signed max. Timing is identical in both builds.

Decomposition:
- Shared package cnn_pkg holds:
  - the state enum p2_state_t {IDLE, FETCH, DRAIN, WRITE, DONE};
  - localparams P2_IN_DIM=8, P2_OUT_DIM=4, PIX_W=8;
  - the pixel typedef pixel_t, logic signed [PIX_W-1:0].
- One sub-module: p2_window_addr.
  - Combinational mapping (r,c,k) to in_addr and (r,c) to out_addr.
  - Reused later by the pooling-1 controller with different parameters.
- Running max, counters and FSM stay in p2_pool_ctrl.

Test Plan:
- Input map in[i]=i for i=0..63, pulse start → 16 writes with out_data = 9,11,13,15,25,...,63 at out_addr 0..15. done rises exactly 97 cycles after the start cycle.
- Window 0 values {-5,-3,-9,-1} (addresses 0,1,8,9) → out_addr 0 gets -1 without the macro, 0 with P2_POOL_CTRL_RELU_EN.
- All 64 inputs = -128 → every output -128 (0 with the macro). Max at position k=3 only, e.g. 127 at address 9 → out[0]=127, checking that DRAIN is captured.
- start pulsed again at cycle 20 mid-pass → ignored: exactly 16 writes, no address reuse, done timing unchanged.
- Reset asserted at cycle 40 → out_we=0, busy=0, done=0 next edge. A later start completes a full, correct pass.
- start while in DONE → done drops next cycle and the second pass reproduces identical outputs. Assert out_we is never high outside WRITE.
